// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcode, ALU code and state definitions for the
// accumulator-processor control sequencer.
package ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEM_RD = 3'd2,
        S_MEM_WR = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    // ALU operation applied on the ACC load for a memory-read instruction.
    function automatic logic [2:0] alu_of(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: sequencer <-> datapath/memory control bundle.
// master = sequencer, slave = datapath and memory side.
interface ctrl_seq_if #(parameter int CNT_W = 8);
    logic [3:0]       ir_op;
    logic             acc_zero;
    logic             mem_rdy;
    logic             mem_req;
    logic             mem_we;
    logic             addr_sel;
    logic             ir_en;
    logic             pc_en;
    logic             pc_sel;
    logic             acc_en;
    logic [2:0]       alu_op;
    logic             retire;
    logic             halted;
    logic [CNT_W-1:0] icnt;

    modport master (
        input  ir_op, acc_zero, mem_rdy,
        output mem_req, mem_we, addr_sel, ir_en, pc_en, pc_sel, acc_en,
               alu_op, retire, halted, icnt
    );

    modport slave (
        output ir_op, acc_zero, mem_rdy,
        input  mem_req, mem_we, addr_sel, ir_en, pc_en, pc_sel, acc_en,
               alu_op, retire, halted, icnt
    );
endinterface

// File: rtl/ctrl_seq_dec.sv
// ctrl_seq_dec: combinational next-state and control-output decoder.
//
// state    | meaning
// ---------+-----------------------------------------------------
// S_FETCH  | read instruction at PC; load IR and step PC on ready
// S_DECODE | one cycle; finish NOP/JMP/JZ/HLT or go to memory phase
// S_MEM_RD | read operand at IR[3:0]; load ACC through ALU on ready
// S_MEM_WR | write ACC to IR[3:0]; retire on ready
// S_HALT   | idle until reset
module ctrl_seq_dec
    import ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [3:0] ir_op,
    input  logic       acc_zero,
    input  logic       rdy,
    output state_e     state_n,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_en,
    output logic       pc_en,
    output logic       pc_sel,
    output logic       acc_en,
    output logic [2:0] alu_op,
    output logic       retire
);

    // Next state and per-state control outputs.
    always_comb begin
        state_n  = state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_en    = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = 1'b0;
        acc_en   = 1'b0;
        alu_op   = ALU_PASS;
        retire   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (rdy) begin
                    ir_en   = 1'b1;
                    pc_en   = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                case (ir_op)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: state_n = S_MEM_RD;
                    OP_STA: state_n = S_MEM_WR;
                    OP_JMP: begin
                        pc_en   = 1'b1;
                        pc_sel  = 1'b1;
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end
                    OP_JZ: begin
                        pc_en   = acc_zero;
                        pc_sel  = acc_zero;
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end
                    OP_HLT: begin
                        retire  = 1'b1;
                        state_n = S_HALT;
                    end
                    default: begin
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end
                endcase
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                alu_op   = alu_of(ir_op);
                if (rdy) begin
                    acc_en  = 1'b1;
                    retire  = 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                if (rdy) begin
                    retire  = 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer top. Holds the state register,
// the halted flag and the retired-instruction counter.
// Optional macro CTRL_SEQ_WAIT_EN: honour mem_rdy wait states; when
// undefined every memory phase completes in one cycle.
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    ctrl_seq_if.master bus
);

    state_e           state;
    state_e           state_n;
    logic             rdy;
    logic             halted_q;
    logic [CNT_W-1:0] icnt_q;

    logic       d_mem_req, d_mem_we, d_addr_sel, d_ir_en, d_pc_en, d_pc_sel;
    logic       d_acc_en, d_retire;
    logic [2:0] d_alu_op;

`ifdef CTRL_SEQ_WAIT_EN
    assign rdy = bus.mem_rdy;
`else
    assign rdy = 1'b1;
`endif

    ctrl_seq_dec u_dec (
        .state    (state),
        .ir_op    (bus.ir_op),
        .acc_zero (bus.acc_zero),
        .rdy      (rdy),
        .state_n  (state_n),
        .mem_req  (d_mem_req),
        .mem_we   (d_mem_we),
        .addr_sel (d_addr_sel),
        .ir_en    (d_ir_en),
        .pc_en    (d_pc_en),
        .pc_sel   (d_pc_sel),
        .acc_en   (d_acc_en),
        .alu_op   (d_alu_op),
        .retire   (d_retire)
    );

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    // Registered halt flag, set on entry to HALT and cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) halted_q <= 1'b0;
        else       halted_q <= (state_n == S_HALT);
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         icnt_q <= '0;
        else if (d_retire) icnt_q <= icnt_q + 1'b1;
    end

    // Combinational controls are held low for the whole reset assertion,
    // including before the state register has seen a clock.
    assign bus.mem_req  = d_mem_req  & ~reset;
    assign bus.mem_we   = d_mem_we   & ~reset;
    assign bus.addr_sel = d_addr_sel & ~reset;
    assign bus.ir_en    = d_ir_en    & ~reset;
    assign bus.pc_en    = d_pc_en    & ~reset;
    assign bus.pc_sel   = d_pc_sel   & ~reset;
    assign bus.acc_en   = d_acc_en   & ~reset;
    assign bus.retire   = d_retire   & ~reset;
    assign bus.alu_op   = reset ? ALU_PASS : d_alu_op;
    assign bus.halted   = halted_q;
    assign bus.icnt     = icnt_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed table, hand-written wait/reset sequences, counter
// wrap and randomized run against an instruction-level reference model.
module tb_ctrl_seq;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   nvec = 0;
    int   nfail = 0;

    ctrl_seq_if #(.CNT_W(8)) bus ();
    ctrl_seq #(.CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus.master));

    always #5 clk = ~clk;

`ifdef CTRL_SEQ_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef struct {
        logic       r;
        logic [3:0] op;
        logic       az;
        logic       rdy;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];

    // {req, we, asel, ir_en, pc_en, pc_sel, acc_en, alu[2:0], retire, halted, icnt[7:0]}
    function automatic logic [19:0] ev(input bit req, we, asel, iren, pcen, pcsel,
                                       accen, input int alu, input bit ret, hlt,
                                       input int ic);
        logic [2:0] a;
        logic [7:0] c;
        a = alu[2:0];
        c = ic[7:0];
        return {req, we, asel, iren, pcen, pcsel, accen, a, ret, hlt, c};
    endfunction

    function automatic logic [19:0] got();
        return {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_en, bus.pc_en,
                bus.pc_sel, bus.acc_en, bus.alu_op, bus.retire, bus.halted, bus.icnt};
    endfunction

    task automatic check(input string nm, input logic [19:0] exp);
        logic [19:0] g;
        g = got();
        nvec++;
        if (g !== exp) begin
            nfail++;
            $display("FAIL %s: got %05h expected %05h (t=%0t)", nm, g, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] op, input logic az, input logic rdy);
        reset        = r;
        bus.ir_op    = op;
        bus.acc_zero = az;
        bus.mem_rdy  = rdy;
    endtask

    // One cycle: drive just after the rising edge, compare on the falling edge.
    task automatic vec(input string nm, input logic r, input logic [3:0] op,
                       input logic az, input logic rdy, input logic [19:0] exp);
        @(posedge clk);
        #1;
        drive(r, op, az, rdy);
        @(negedge clk);
        check(nm, exp);
    endtask

    task automatic add(input logic r, input logic [3:0] op, input logic az,
                       input logic rdy, input logic [19:0] exp);
        vec_t v;
        v.r = r; v.op = op; v.az = az; v.rdy = rdy; v.exp = exp;
        tbl.push_back(v);
    endtask

    // Reference model: instruction phases and opcode classes.
    localparam int P_FETCH = 0, P_DEC = 1, P_MEM = 2, P_HALT = 3;
    int m_phase, m_icnt;
    bit m_halt;

    function automatic bit is_read(input int op);
        return op == 1 || (op >= 3 && op <= 6);
    endfunction

    function automatic int alu_for(input int op);
        return (op >= 3 && op <= 6) ? op - 2 : 0;
    endfunction

    function automatic logic [19:0] model_exp(input bit r, input int op, input bit az, input bit rdy);
        bit re, req, we, asel, iren, pcen, pcsel, accen, ret;
        int alu;
        re = rdy || !WAIT_EN;
        {req, we, asel, iren, pcen, pcsel, accen, ret} = '0;
        alu = 0;
        if (r) return '0;
        if (m_phase == P_FETCH) begin
            req = 1;
            iren = re;
            pcen = re;
        end else if (m_phase == P_DEC) begin
            pcsel = (op == 7) || (op == 8 && az);
            pcen  = pcsel;
            ret   = !is_read(op) && op != 2;
        end else if (m_phase == P_MEM) begin
            req = 1;
            asel = 1;
            we = (op == 2);
            alu = (op == 2) ? 0 : alu_for(op);
            ret = re;
            accen = re && op != 2;
        end
        return ev(req, we, asel, iren, pcen, pcsel, accen, alu, ret, m_halt, m_icnt);
    endfunction

    task automatic model_step(input bit r, input int op, input bit rdy, input bit ret);
        bit re;
        re = rdy || !WAIT_EN;
        if (r) begin
            m_phase = P_FETCH;
            m_icnt  = 0;
        end else begin
            if (ret) m_icnt = (m_icnt + 1) % 256;
            case (m_phase)
                P_FETCH: if (re) m_phase = P_DEC;
                P_DEC:   m_phase = (is_read(op) || op == 2) ? P_MEM : (op == 15 ? P_HALT : P_FETCH);
                P_MEM:   if (re) m_phase = P_FETCH;
                default: m_phase = P_HALT;
            endcase
        end
        m_halt = (m_phase == P_HALT);
    endtask

    initial begin
        logic [19:0] e;
        logic [3:0]  rop;
        bit          rr, raz, rrdy;

        drive(1'b1, 4'h0, 1'b0, 1'b0);

        // Directed table, zero wait states.
        add(1, 4'h0, 0, 1, ev(0,0,0,0,0,0,0,0,0,0,0));
        add(0, 4'h0, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,0));
        add(0, 4'h0, 0, 1, ev(0,0,0,0,0,0,0,0,1,0,0));
        add(0, 4'h0, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,1));
        add(0, 4'h0, 0, 1, ev(0,0,0,0,0,0,0,0,1,0,1));
        add(0, 4'h0, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,2));
        add(0, 4'h0, 0, 1, ev(0,0,0,0,0,0,0,0,1,0,2));
        add(0, 4'h3, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,3));
        add(0, 4'h3, 0, 1, ev(0,0,0,0,0,0,0,0,0,0,3));
        add(0, 4'h3, 0, 1, ev(1,0,1,0,0,0,1,1,1,0,3));
        add(0, 4'h2, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,4));
        add(0, 4'h2, 0, 1, ev(0,0,0,0,0,0,0,0,0,0,4));
        add(0, 4'h2, 0, 1, ev(1,1,1,0,0,0,0,0,1,0,4));
        add(0, 4'h8, 1, 1, ev(1,0,0,1,1,0,0,0,0,0,5));
        add(0, 4'h8, 1, 1, ev(0,0,0,0,1,1,0,0,1,0,5));
        add(0, 4'h8, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,6));
        add(0, 4'h8, 0, 1, ev(0,0,0,0,0,0,0,0,1,0,6));
        add(0, 4'h7, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,7));
        add(0, 4'h7, 0, 1, ev(0,0,0,0,1,1,0,0,1,0,7));
        add(0, 4'h1, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,8));
        add(0, 4'h1, 0, 1, ev(0,0,0,0,0,0,0,0,0,0,8));
        add(0, 4'h1, 0, 1, ev(1,0,1,0,0,0,1,0,1,0,8));
        add(0, 4'h4, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,9));
        add(0, 4'h4, 0, 1, ev(0,0,0,0,0,0,0,0,0,0,9));
        add(0, 4'h4, 0, 1, ev(1,0,1,0,0,0,1,2,1,0,9));
        add(0, 4'h5, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,10));
        add(0, 4'h5, 0, 1, ev(0,0,0,0,0,0,0,0,0,0,10));
        add(0, 4'h5, 0, 1, ev(1,0,1,0,0,0,1,3,1,0,10));
        add(0, 4'h6, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,11));
        add(0, 4'h6, 0, 1, ev(0,0,0,0,0,0,0,0,0,0,11));
        add(0, 4'h6, 0, 1, ev(1,0,1,0,0,0,1,4,1,0,11));
        add(0, 4'hB, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,12));
        add(0, 4'hB, 0, 1, ev(0,0,0,0,0,0,0,0,1,0,12));
        add(0, 4'hF, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,13));
        add(0, 4'hF, 0, 1, ev(0,0,0,0,0,0,0,0,1,0,13));
        add(0, 4'h3, 1, 1, ev(0,0,0,0,0,0,0,0,0,1,14));
        add(0, 4'h7, 1, 1, ev(0,0,0,0,0,0,0,0,0,1,14));
        add(1, 4'h0, 0, 1, ev(0,0,0,0,0,0,0,0,0,0,0));
        add(0, 4'h0, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++)
            vec($sformatf("tbl[%0d]", i), tbl[i].r, tbl[i].op, tbl[i].az, tbl[i].rdy, tbl[i].exp);

        // Wait states in FETCH, MEM_RD and MEM_WR.
        vec("rst", 1, 4'h0, 0, 1, ev(0,0,0,0,0,0,0,0,0,0,0));
`ifdef CTRL_SEQ_WAIT_EN
        vec("fetch_wait", 0, 4'h3, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0));
        vec("fetch_rdy",  0, 4'h3, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,0));
        vec("add_dec",    0, 4'h3, 0, 0, ev(0,0,0,0,0,0,0,0,0,0,0));
        vec("add_wait1",  0, 4'h3, 0, 0, ev(1,0,1,0,0,0,0,1,0,0,0));
        vec("add_wait2",  0, 4'h3, 0, 0, ev(1,0,1,0,0,0,0,1,0,0,0));
        vec("add_rdy",    0, 4'h3, 0, 1, ev(1,0,1,0,0,0,1,1,1,0,0));
        vec("sta_fetch",  0, 4'h2, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,1));
        vec("sta_dec",    0, 4'h2, 0, 1, ev(0,0,0,0,0,0,0,0,0,0,1));
        vec("sta_wait",   0, 4'h2, 0, 0, ev(1,1,1,0,0,0,0,0,0,0,1));
        vec("sta_rdy",    0, 4'h2, 0, 1, ev(1,1,1,0,0,0,0,0,1,0,1));
`else
        vec("add_fetch",  0, 4'h3, 0, 0, ev(1,0,0,1,1,0,0,0,0,0,0));
        vec("add_dec",    0, 4'h3, 0, 0, ev(0,0,0,0,0,0,0,0,0,0,0));
        vec("add_norw",   0, 4'h3, 0, 0, ev(1,0,1,0,0,0,1,1,1,0,0));
        vec("sta_fetch",  0, 4'h2, 0, 0, ev(1,0,0,1,1,0,0,0,0,0,1));
        vec("sta_dec",    0, 4'h2, 0, 0, ev(0,0,0,0,0,0,0,0,0,0,1));
        vec("sta_norw",   0, 4'h2, 0, 0, ev(1,1,1,0,0,0,0,0,1,0,1));
`endif
        // Reset in the middle of a memory-read cycle (a wait when enabled).
        vec("lda_fetch", 0, 4'h1, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,2));
        vec("lda_dec",   0, 4'h1, 0, 1, ev(0,0,0,0,0,0,0,0,0,0,2));
        e = WAIT_EN ? ev(1,0,1,0,0,0,0,0,0,0,2) : ev(1,0,1,0,0,0,1,0,1,0,2);
        vec("lda_mem", 0, 4'h1, 0, 0, e);
        #1;
        reset = 1'b1;
        #1;
        check("mid_reset", ev(0,0,0,0,0,0,0,0,0,0,0));
        vec("mid_reset_hold", 1, 4'h1, 0, 0, ev(0,0,0,0,0,0,0,0,0,0,0));
        vec("after_reset", 0, 4'h1, 0, 1, ev(1,0,0,1,1,0,0,0,0,0,0));

        // Counter wrap: 256 NOP retirements.
        vec("rst_wrap", 1, 4'h0, 0, 1, ev(0,0,0,0,0,0,0,0,0,0,0));
        for (int c = 1; c <= 513; c++) begin
            @(posedge clk);
            #1;
            drive(1'b0, 4'h0, 1'b0, 1'b1);
            @(negedge clk);
            if (c == 511) check("icnt_255", ev(1,0,0,1,1,0,0,0,0,0,255));
            if (c == 513) check("icnt_wrap", ev(1,0,0,1,1,0,0,0,0,0,0));
        end

        // Randomized run against the reference model.
        m_phase = P_FETCH;
        m_icnt  = 0;
        m_halt  = 0;
        rop     = 4'h0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rr = (c == 0) || ($urandom_range(0, 199) == 0) ||
                 (m_phase == P_HALT && $urandom_range(0, 3) == 0);
            if (m_phase == P_FETCH || m_phase == P_HALT) begin
                rop = 4'($urandom_range(0, 15));
                if (rop == 4'hF && $urandom_range(0, 3) != 0) rop = 4'h0;
            end
            raz  = 1'($urandom_range(0, 1));
            rrdy = ($urandom_range(0, 3) != 0);
            drive(rr, rop, raz, rrdy);
            @(negedge clk);
            e = model_exp(rr, int'(rop), raz, rrdy);
            check("rand", e);
            model_step(rr, int'(rop), rrdy, e[9]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
